video_timing_gen: RTL and testbench
===================================

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640: active pixels per line.
REQ-002 SHALL have parameter H_FP, default 16: horizontal front porch, in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96: hsync pulse width, in pixels.
REQ-004 SHALL have parameter H_BP, default 48: horizontal back porch, in pixels.
REQ-005 SHALL have parameter V_ACTIVE, default 480: active lines per frame.
REQ-006 SHALL have parameter V_FP, default 10: vertical front porch, in lines.
REQ-007 SHALL have parameter V_SYNC, default 2: vsync pulse width, in lines.
REQ-008 SHALL have parameter V_BP, default 33: vertical back porch, in lines.
REQ-009 SHALL have parameters HS_POL and VS_POL, default 0 each: sync active level (0 = active-low).
REQ-010 SHALL have clk_pix, input, 1 bit: pixel clock; sole clock of the block.
REQ-011 SHALL have rst_n, input, 1 bit: asynchronous active-low reset.
REQ-012 SHALL have hsync_o, output, 1 bit: horizontal sync, feeds the downstream DVI core hsync input.
REQ-013 SHALL have vsync_o, output, 1 bit: vertical sync, feeds the DVI core vsync input.
REQ-014 SHALL have de_o, output, 1 bit: display enable, high in the active area.
REQ-015 SHALL have x_o, output, 12 bits: active-area column; valid while de_o=1.
REQ-016 SHALL have y_o, output, 12 bits: active-area row; valid while de_o=1.
REQ-017 SHALL have frame_start_o, output, 1 bit: one-cycle pulse at pixel (0,0).
REQ-018 SHALL have line_start_o, output, 1 bit: one-cycle pulse at x=0 of every line, active and blanking.

Function
REQ-019 SHALL define H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
REQ-020 SHALL keep a horizontal counter h_cnt that counts 0..H_TOTAL-1, increments every clk_pix, and wraps to 0.
REQ-021 SHALL keep a vertical counter v_cnt that increments only when h_cnt wraps, counts 0..V_TOTAL-1, and wraps to 0 on the same edge as h_cnt when both are at their maximum.
REQ-022 SHALL place each line in the order active, front porch, sync, back porch; vertical uses the same order.
REQ-023 SHALL assert hsync at HS_POL while H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC; vsync is asserted likewise on v_cnt, for whole lines.
REQ-024 SHALL drive de high exactly when h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
REQ-025 SHALL drive x_o=h_cnt and y_o=v_cnt when de is high, and 0 otherwise.
REQ-026 SHALL assert frame_start when h_cnt=0 and v_cnt=0, and line_start when h_cnt=0.
REQ-027 SHALL register all outputs: each output is a function of the counter values in the previous cycle (1-cycle latency), so all outputs are mutually aligned.
REQ-028 SHALL produce no glitches on any output, since every output comes straight from a flop.
REQ-029 SHALL produce, per frame, exactly H_ACTIVE*V_ACTIVE cycles with de_o=1, V_TOTAL line_start pulses and 1 frame_start pulse.

Reset
REQ-030 SHALL, while rst_n=0, hold h_cnt=0, v_cnt=0, de_o=0, x_o=0, y_o=0, frame_start_o=0, line_start_o=0, hsync_o=~HS_POL and vsync_o=~VS_POL.
REQ-031 SHALL, on the first clk_pix rising edge after rst_n deasserts, drive de_o=1, x_o=0, y_o=0, frame_start_o=1 and line_start_o=1.
REQ-032 SHALL, on rst_n assertion mid-frame, force outputs to reset values immediately (asynchronously) and restart the frame from (0,0) after release.

Structure
REQ-033 SHALL place the 12-bit coordinate width and the default 640x480@60 timing constants in a shared video timing package, reused by the DVI top and pattern sources.
REQ-034 SHALL be one flat module with no sub-modules; the horizontal and vertical counter-plus-decode may be two always blocks of identical form.

Verification
REQ-035 SHALL cover reset release with defaults -> next edge de_o=1, x_o=0, y_o=0, frame_start_o=1, hsync_o=1, vsync_o=1.
REQ-036 SHALL cover one full line -> de_o high 640 cycles, then hsync_o low for exactly 96 cycles starting 656 cycles after line_start_o, with period 800.
REQ-037 SHALL cover one full frame -> 307200 de_o cycles, vsync_o low for 2 lines (1600 cycles) starting at line 490, with frame_start_o period 420000.
REQ-038 SHALL cover wrap at h_cnt=799, v_cnt=524 -> the next output cycle has x_o=0, y_o=0, frame_start_o=1 and no extra line_start_o.
REQ-039 SHALL cover rst_n pulsed low at line 200, pixel 300 -> outputs go to reset values asynchronously and the frame restarts at (0,0).
REQ-040 SHALL cover override of parameters to 4/1/2/1 x 3/1/1/1 with HS_POL=VS_POL=1 -> H_TOTAL=8, V_TOTAL=6, active-high syncs at the correct counts.

Source files
------------

// File: rtl/video_timing_gen_pkg.sv
// Shared video timing definitions: coordinate width, default 640x480@60 timing
// and the line/frame region decode used by the timing generator and pattern sources.
package video_timing_gen_pkg;

    localparam int COORD_W = 12;

    typedef logic [COORD_W-1:0] coord_t;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    typedef enum logic [1:0] {
        REG_ACTIVE,
        REG_FP,
        REG_SYNC,
        REG_BP
    } region_e;

    // Regions follow each other as active, front porch, sync, back porch.
    function automatic region_e regionOf(
        input coord_t cnt,
        input int     active,
        input int     fp,
        input int     sync
    );
        int c;
        c = int'(cnt);
        if (c < active) begin
            return REG_ACTIVE;
        end else if (c < active + fp) begin
            return REG_FP;
        end else if (c < active + fp + sync) begin
            return REG_SYNC;
        end else begin
            return REG_BP;
        end
    endfunction

endpackage

// File: rtl/video_timing_gen.sv
// Raster timing generator: free-running pixel/line counters with a registered
// decode of sync, display enable, active-area coordinates and start pulses.
module video_timing_gen
    import video_timing_gen_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic               clk_pix,
    input  logic               rst_n,
    output logic               hsync_o,
    output logic               vsync_o,
    output logic               de_o,
    output logic [COORD_W-1:0] x_o,
    output logic [COORD_W-1:0] y_o,
    output logic               frame_start_o,
    output logic               line_start_o
);

    localparam int     H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int     V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam coord_t H_LAST  = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST  = coord_t'(V_TOTAL - 1);

    coord_t  r_hCnt;
    coord_t  r_vCnt;
    logic    w_hWrap;
    logic    w_vWrap;
    region_e w_hRegion;
    region_e w_vRegion;
    logic    w_de;

    assign w_hWrap   = (r_hCnt == H_LAST);
    assign w_vWrap   = (r_vCnt == V_LAST);
    assign w_hRegion = regionOf(r_hCnt, H_ACTIVE, H_FP, H_SYNC);
    assign w_vRegion = regionOf(r_vCnt, V_ACTIVE, V_FP, V_SYNC);
    assign w_de      = (w_hRegion == REG_ACTIVE) && (w_vRegion == REG_ACTIVE);

    // Every output is decoded from the counters' current value and registered,
    // so all outputs lag the counters by one cycle and stay mutually aligned.
    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            r_hCnt       <= '0;
            hsync_o      <= ~HS_POL;
            line_start_o <= 1'b0;
        end else begin
            r_hCnt       <= w_hWrap ? '0 : r_hCnt + coord_t'(1);
            hsync_o      <= (w_hRegion == REG_SYNC) ? HS_POL : ~HS_POL;
            line_start_o <= (r_hCnt == '0);
        end
    end

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            r_vCnt  <= '0;
            vsync_o <= ~VS_POL;
        end else begin
            if (w_hWrap) begin
                r_vCnt <= w_vWrap ? '0 : r_vCnt + coord_t'(1);
            end
            vsync_o <= (w_vRegion == REG_SYNC) ? VS_POL : ~VS_POL;
        end
    end

    // Coordinates are forced to zero outside the active area.
    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            de_o          <= 1'b0;
            x_o           <= '0;
            y_o           <= '0;
            frame_start_o <= 1'b0;
        end else begin
            de_o          <= w_de;
            x_o           <= w_de ? r_hCnt : '0;
            y_o           <= w_de ? r_vCnt : '0;
            frame_start_o <= (r_hCnt == '0) && (r_vCnt == '0);
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench: a default 640x480 instance and a tiny 8x6 active-high
// instance run side by side against a cycle-accurate reference scoreboard.
`timescale 1ns/1ps
module tb_video_timing_gen;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [11:0] x;
        logic [11:0] y;
        logic        fs;
        logic        ls;
    } outs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0N;
    logic        rst1N;
    logic        hs0, vs0, de0, fs0, ls0;
    logic [11:0] x0, y0;
    logic        hs1, vs1, de1, fs1, ls1;
    logic [11:0] x1, y1;

    video_timing_gen dut0 (
        .clk_pix       (clk),
        .rst_n         (rst0N),
        .hsync_o       (hs0),
        .vsync_o       (vs0),
        .de_o          (de0),
        .x_o           (x0),
        .y_o           (y0),
        .frame_start_o (fs0),
        .line_start_o  (ls0)
    );

    video_timing_gen #(
        .H_ACTIVE (4), .H_FP (1), .H_SYNC (2), .H_BP (1),
        .V_ACTIVE (3), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .HS_POL   (1'b1), .VS_POL (1'b1)
    ) dut1 (
        .clk_pix       (clk),
        .rst_n         (rst1N),
        .hsync_o       (hs1),
        .vsync_o       (vs1),
        .de_o          (de1),
        .x_o           (x1),
        .y_o           (y1),
        .frame_start_o (fs1),
        .line_start_o  (ls1)
    );

    int    checks = 0;
    int    errors = 0;
    outs_t q0[$];
    outs_t q1[$];
    int    m0h = 0, m0v = 0, m1h = 0, m1v = 0;

    // Reference raster decode for one (h, v) position.
    function automatic outs_t modelOut(input int h, input int v,
                                       input int ha, input int hf, input int hsw,
                                       input int va, input int vf, input int vsw,
                                       input bit hp, input bit vp);
        outs_t o;
        o.hs = (h >= ha + hf && h < ha + hf + hsw) ? hp : ~hp;
        o.vs = (v >= va + vf && v < va + vf + vsw) ? vp : ~vp;
        o.de = (h < ha) && (v < va);
        o.x  = o.de ? 12'(h) : 12'd0;
        o.y  = o.de ? 12'(v) : 12'd0;
        o.fs = (h == 0) && (v == 0);
        o.ls = (h == 0);
        return o;
    endfunction

    function automatic outs_t resetOut(input bit hp, input bit vp);
        outs_t o;
        o    = '0;
        o.hs = ~hp;
        o.vs = ~vp;
        return o;
    endfunction

    task automatic advance(inout int h, inout int v, input int ht, input int vt);
        if (h == ht - 1) begin
            h = 0;
            v = (v == vt - 1) ? 0 : v + 1;
        end else begin
            h = h + 1;
        end
    endtask

    // One pixel clock: push what each DUT must show after this edge, then pop and compare.
    task automatic runCycle();
        outs_t exp0, exp1, got0, got1;
        q0.push_back(rst0N ? modelOut(m0h, m0v, 640, 16, 96, 480, 10, 2, 1'b0, 1'b0)
                           : resetOut(1'b0, 1'b0));
        q1.push_back(rst1N ? modelOut(m1h, m1v, 4, 1, 2, 3, 1, 1, 1'b1, 1'b1)
                           : resetOut(1'b1, 1'b1));
        @(posedge clk);
        if (rst0N) advance(m0h, m0v, 800, 525);
        if (rst1N) advance(m1h, m1v, 8, 6);
        #1;
        exp0 = q0.pop_front();
        exp1 = q1.pop_front();
        got0 = {hs0, vs0, de0, x0, y0, fs0, ls0};
        got1 = {hs1, vs1, de1, x1, y1, fs1, ls1};
        checks++;
        if (got0 !== exp0) begin
            errors++;
            $display("[TB] FAIL sb0 t=%0t: got %h exp %h", $time, got0, exp0);
        end
        checks++;
        if (got1 !== exp1) begin
            errors++;
            $display("[TB] FAIL sb1 t=%0t: got %h exp %h", $time, got1, exp1);
        end
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        rst0N = 1'b1;
        rst1N = 1'b1;
        #2;
        rst0N = 1'b0;
        rst1N = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({hs0, vs0, de0, x0, y0, fs0, ls0} !== resetOut(1'b0, 1'b0)) begin
            errors++;
            $display("[TB] FAIL reset0: got %h exp %h", {hs0, vs0, de0, x0, y0, fs0, ls0},
                     resetOut(1'b0, 1'b0));
        end
        checks++;
        if ({hs1, vs1, de1, x1, y1, fs1, ls1} !== resetOut(1'b1, 1'b1)) begin
            errors++;
            $display("[TB] FAIL reset1: got %h exp %h", {hs1, vs1, de1, x1, y1, fs1, ls1},
                     resetOut(1'b1, 1'b1));
        end
        m0h = 0; m0v = 0; m1h = 0; m1v = 0;
        rst0N = 1'b1;
        rst1N = 1'b1;
    endtask

    task automatic test_first_edge();
        $display("[TB] test_first_edge");
        runCycle();
        checks++;
        if ({de0, x0, y0, fs0, ls0, hs0, vs0} !== {1'b1, 12'd0, 12'd0, 1'b1, 1'b1, 1'b1, 1'b1}) begin
            errors++;
            $display("[TB] FAIL first_edge0: got de=%b x=%0d y=%0d fs=%b ls=%b hs=%b vs=%b exp 1 0 0 1 1 1 1",
                     de0, x0, y0, fs0, ls0, hs0, vs0);
        end
        checks++;
        if ({de1, fs1, ls1, hs1, vs1} !== 5'b11100) begin
            errors++;
            $display("[TB] FAIL first_edge1: got de=%b fs=%b ls=%b hs=%b vs=%b exp 1 1 1 0 0",
                     de1, fs1, ls1, hs1, vs1);
        end
    endtask

    task automatic test_line();
        int waitCnt, deCnt, hsLow, hsStart;
        $display("[TB] test_line");
        waitCnt = 0;
        do begin
            runCycle();
            waitCnt++;
        end while (!ls0 && waitCnt < 1000);
        checks++;
        if (!ls0) begin
            errors++;
            $display("[TB] FAIL line_wait: got no line_start in %0d cycles exp one", waitCnt);
        end
        deCnt = 0; hsLow = 0; hsStart = -1;
        for (int i = 0; i < 800; i++) begin
            if (i > 0) runCycle();
            if (de0) deCnt++;
            if (!hs0) begin
                hsLow++;
                if (hsStart < 0) hsStart = i;
            end
        end
        runCycle();
        checks++;
        if (deCnt !== 640) begin
            errors++;
            $display("[TB] FAIL line_de: got %0d exp 640", deCnt);
        end
        checks++;
        if (hsLow !== 96) begin
            errors++;
            $display("[TB] FAIL line_hs_width: got %0d exp 96", hsLow);
        end
        checks++;
        if (hsStart !== 656) begin
            errors++;
            $display("[TB] FAIL line_hs_start: got %0d exp 656", hsStart);
        end
        checks++;
        if (ls0 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL line_period: got ls=%b at cycle 800 exp 1", ls0);
        end
    endtask

    task automatic test_small_frame();
        int waitCnt, deCnt, lsCnt, fsCnt, hsHigh, hsStart, vsHigh, vsStart;
        $display("[TB] test_small_frame");
        waitCnt = 0;
        do begin
            runCycle();
            waitCnt++;
        end while (!fs1 && waitCnt < 100);
        checks++;
        if (!fs1) begin
            errors++;
            $display("[TB] FAIL frame_wait: got no frame_start in %0d cycles exp one", waitCnt);
        end
        deCnt = 0; lsCnt = 0; fsCnt = 0; hsHigh = 0; vsHigh = 0; hsStart = -1; vsStart = -1;
        for (int i = 0; i < 48; i++) begin
            if (i > 0) runCycle();
            if (de1) deCnt++;
            if (ls1) lsCnt++;
            if (fs1) fsCnt++;
            if (hs1) begin
                hsHigh++;
                if (hsStart < 0) hsStart = i;
            end
            if (vs1) begin
                vsHigh++;
                if (vsStart < 0) vsStart = i;
            end
        end
        checks++;
        if ({deCnt, lsCnt, fsCnt} !== {32'd12, 32'd6, 32'd1}) begin
            errors++;
            $display("[TB] FAIL frame_counts: got de=%0d ls=%0d fs=%0d exp 12 6 1", deCnt, lsCnt, fsCnt);
        end
        checks++;
        if ({hsHigh, hsStart} !== {32'd12, 32'd5}) begin
            errors++;
            $display("[TB] FAIL frame_hsync: got width=%0d start=%0d exp 12 5", hsHigh, hsStart);
        end
        checks++;
        if ({vsHigh, vsStart} !== {32'd8, 32'd32}) begin
            errors++;
            $display("[TB] FAIL frame_vsync: got width=%0d start=%0d exp 8 32", vsHigh, vsStart);
        end
        runCycle();
        checks++;
        if ({fs1, ls1, de1, x1, y1} !== {1'b1, 1'b1, 1'b1, 12'd0, 12'd0}) begin
            errors++;
            $display("[TB] FAIL frame_wrap: got fs=%b ls=%b de=%b x=%0d y=%0d exp 1 1 1 0 0",
                     fs1, ls1, de1, x1, y1);
        end
    endtask

    task automatic test_back_to_back();
        int fsCnt, lsCnt;
        $display("[TB] test_back_to_back");
        fsCnt = 0; lsCnt = 0;
        for (int i = 0; i < 3 * 48; i++) begin
            runCycle();
            if (fs1) fsCnt++;
            if (ls1) lsCnt++;
        end
        checks++;
        if ({fsCnt, lsCnt} !== {32'd3, 32'd18}) begin
            errors++;
            $display("[TB] FAIL b2b_counts: got fs=%0d ls=%0d exp 3 18", fsCnt, lsCnt);
        end
    endtask

    task automatic test_mid_reset();
        int waitCnt;
        $display("[TB] test_mid_reset");
        waitCnt = 0;
        while (!(m1v == 2 && m1h == 3) && waitCnt < 100) begin
            runCycle();
            waitCnt++;
        end
        checks++;
        if (!(m1v == 2 && m1h == 3)) begin
            errors++;
            $display("[TB] FAIL mid_wait: got position %0d,%0d exp 2,3", m1v, m1h);
        end
        #3;
        rst0N = 1'b0;
        rst1N = 1'b0;
        #1;
        checks++;
        if ({hs0, vs0, de0, x0, y0, fs0, ls0} !== resetOut(1'b0, 1'b0)) begin
            errors++;
            $display("[TB] FAIL async_reset0: got %h exp %h", {hs0, vs0, de0, x0, y0, fs0, ls0},
                     resetOut(1'b0, 1'b0));
        end
        checks++;
        if ({hs1, vs1, de1, x1, y1, fs1, ls1} !== resetOut(1'b1, 1'b1)) begin
            errors++;
            $display("[TB] FAIL async_reset1: got %h exp %h", {hs1, vs1, de1, x1, y1, fs1, ls1},
                     resetOut(1'b1, 1'b1));
        end
        m0h = 0; m0v = 0; m1h = 0; m1v = 0;
        repeat (2) runCycle();
        rst0N = 1'b1;
        rst1N = 1'b1;
        runCycle();
        checks++;
        if ({fs0, ls0, de0, x0, y0, fs1, x1, y1} !== {3'b111, 24'd0, 1'b1, 24'd0}) begin
            errors++;
            $display("[TB] FAIL restart: got fs0=%b ls0=%b de0=%b x0=%0d y0=%0d fs1=%b x1=%0d y1=%0d exp 1 1 1 0 0 1 0 0",
                     fs0, ls0, de0, x0, y0, fs1, x1, y1);
        end
        repeat (60) runCycle();
    endtask

    initial begin
        rst0N = 1'b1;
        rst1N = 1'b1;
        test_reset();
        test_first_edge();
        test_line();
        test_small_frame();
        test_back_to_back();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
